// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Flush kills held entries; saturating counters report stall, bubble and flush activity.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mData_q, mData_d, sData_q, sData_d;
  logic [CTRL_W-1:0] mCtrl_q, mCtrl_d, sCtrl_q, sCtrl_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
  logic              inFire, outFire;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign occupancy  = state_q;
  assign out_data   = mData_q;
  assign out_ctrl   = mCtrl_q;
  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
  assign flush_cnt  = flushCnt_q;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    mData_d = mData_q;
    mCtrl_d = mCtrl_q;
    sData_d = sData_q;
    sCtrl_d = sCtrl_q;
    if (flush) begin
      // Data is left in place; only control is scrubbed so nothing downstream acts on it.
      state_d = EMPTY;
      mCtrl_d = '0;
      sCtrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            mData_d = in_data;
            mCtrl_d = in_ctrl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mData_d = in_data;
            mCtrl_d = in_ctrl;
          end else if (inFire) begin
            sData_d = in_data;
            sCtrl_d = in_ctrl;
            state_d = FULL;
          end else if (outFire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            mData_d = sData_q;
            mCtrl_d = sCtrl_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Counters saturate rather than wrap; a clear beats any increment in the same cycle.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    flushCnt_d  = flushCnt_q;
    if (cnt_clr) begin
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
      flushCnt_d  = '0;
    end else begin
      if (out_valid && !out_ready && stallCnt_q != CNT_MAX)
        stallCnt_d = stallCnt_q + CNT_ONE;
      if (!out_valid && bubbleCnt_q != CNT_MAX)
        bubbleCnt_d = bubbleCnt_q + CNT_ONE;
      if (flush && out_valid && flushCnt_q != CNT_MAX)
        flushCnt_d = flushCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      mData_q     <= '0;
      mCtrl_q     <= '0;
      sData_q     <= '0;
      sCtrl_q     <= '0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mData_q     <= mData_d;
      mCtrl_q     <= mCtrl_d;
      sData_q     <= sData_d;
      sCtrl_q     <= sCtrl_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expected entries, a monitor pops them
// whenever the stage hands an entry downstream.
module tb_pipe_stage_reg;

  localparam int DW   = 128;
  localparam int CW   = 16;
  localparam int CNTW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } expItem_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          cnt_clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] bubble_cnt;
  logic [CNTW-1:0] flush_cnt;

  expItem_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
    ctrlOf = {8'hC0, d[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checkCount++;
    if (act !== req)
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    else
      passCount++;
  endtask

  // Drive one cycle of inputs; accepted entries are hand-marked and queued for the monitor.
  task automatic applyStimulus(input logic inV, input logic [DW-1:0] d, input logic outR,
                               input logic fl, input logic clr, input logic expAccept);
    in_valid  = inV;
    in_data   = d;
    in_ctrl   = ctrlOf(d);
    out_ready = outR;
    flush     = fl;
    cnt_clr   = clr;
    if (expAccept) expQ.push_back('{data: d, ctrl: ctrlOf(d)});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    expItem_t e;
    if (!rst && out_valid && out_ready) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpectedOutput: got data=%0h ctrl=%0h, required no entry", out_data, out_ctrl);
      end else begin
        e = expQ.pop_front();
        if (out_data !== e.data || out_ctrl !== e.ctrl)
          $display("[TB] FAIL scoreboard: got data=%0h ctrl=%0h, required data=%0h ctrl=%0h",
                   out_data, out_ctrl, e.data, e.ctrl);
        else
          passCount++;
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 128'hDEAD; in_ctrl = 16'hFFFF; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("resetOutValid",  out_valid,  0);
    checkOutput("resetInReady",   in_ready,   1);
    checkOutput("resetOcc",       occupancy,  0);
    checkOutput("resetOutData",   out_data,   0);
    checkOutput("resetOutCtrl",   out_ctrl,   0);
    checkOutput("resetBubble",    bubble_cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Streaming at full rate with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("streamInReady", in_ready,  1);
      checkOutput("streamOcc",     occupancy, 1);
      checkOutput("streamData",    out_data,  DW'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("streamDrainOcc", occupancy, 0);
    checkOutput("streamStall",    stall_cnt, 0);

    // One-cycle back-pressure absorbed by the skid entry.
    applyStimulus(1'b1, 128'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("skidOcc",     occupancy, 2);
    checkOutput("skidInReady", in_ready,  0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("skidOccAfter",  occupancy, 1);
    checkOutput("skidReadyBack", in_ready,  1);
    checkOutput("skidHead",      out_data,  128'h11);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("skidStall", stall_cnt, 1);
    checkOutput("skidEmpty", occupancy, 0);

    // Flush while full with an entry offered upstream.
    applyStimulus(1'b1, 128'h1A, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'h1B, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("flushPreOcc", occupancy, 2);
    applyStimulus(1'b1, 128'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    expQ.delete();
    checkOutput("flushOutValid", out_valid, 0);
    checkOutput("flushOutCtrl",  out_ctrl,  0);
    checkOutput("flushOcc",      occupancy, 0);
    checkOutput("flushCnt",      flush_cnt, 1);
    checkOutput("flushDataHeld", out_data,  128'h1A);
    checkOutput("flushStall",    stall_cnt, 3);
    applyStimulus(1'b1, 128'h21, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("flushEmptyCnt", flush_cnt, 1);
    checkOutput("flushEmptyOcc", occupancy, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("flushDiscarded", out_valid, 0);

    // Counter saturation and clear priority.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clrFlush", flush_cnt, 0);
    checkOutput("clrStall", stall_cnt, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bubbleSat", bubble_cnt, 15);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("bubbleClr", bubble_cnt, 0);

    // Asynchronous reset between edges while full.
    applyStimulus(1'b1, 128'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'h31, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("arstPreOcc", occupancy, 2);
    #2;
    rst = 1'b1;
    #1;
    expQ.delete();
    checkOutput("arstOutValid", out_valid,  0);
    checkOutput("arstInReady",  in_ready,   1);
    checkOutput("arstOcc",      occupancy,  0);
    checkOutput("arstStall",    stall_cnt,  0);
    checkOutput("arstOutData",  out_data,   0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 128'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("postRstValid", out_valid, 1);
    checkOutput("postRstData",  out_data,  128'h40);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("postRstDrain", occupancy, 0);

    checkOutput("queueDrained", DW'(expQ.size()), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
